// File: rtl/pwm_pulse_gen.sv
// pwm_pulse_gen
//   Responder end of the PID-to-motor PWM handshake. Captures magnitude and
//   direction requests, applies them on frame boundaries and produces an
//   RC-servo style pulse train (NEUTRAL_US +/- up to 498 us) for a Spark MAX.
//
//   Optional build macro PWM_SLEW_LIMIT_EN: when defined, the active value
//   walks toward the request by at most SLEW_STEP per frame, passing through
//   zero on a direction reversal. When undefined, a request takes effect in
//   one step at the next boundary.
//
// Ports
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   pwm_enable     1 = generate pulses, 0 = output low, counters cleared
//   pwm_ratio      requested magnitude 0..255
//   pwm_direction  0 = forward (longer pulse), 1 = reverse (shorter pulse)
//   pwm_update     one-cycle strobe capturing pwm_ratio/pwm_direction
//   pwm_done       one-cycle pulse when a request becomes the active value
//   pwm_signal     registered PWM output to the motor controller
//   period_start   one-cycle pulse on the first cycle of every frame
module pwm_pulse_gen #(
    parameter int CYCLES_PER_US = 27,
    parameter int PERIOD_US     = 5000,
    parameter int NEUTRAL_US    = 1500,
    parameter int SLEW_STEP     = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pwm_enable,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    input  logic       pwm_update,
    output logic       pwm_done,
    output logic       pwm_signal,
    output logic       period_start
);

    localparam int PRE_W = $clog2(CYCLES_PER_US + 1);
    localparam int CNT_W = $clog2(PERIOD_US + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_US - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_US - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] NEUTRAL  = CNT_W'(NEUTRAL_US);

    // The pulse must fit inside the frame in both directions.
    if (PERIOD_US <= 2000 || NEUTRAL_US < 498 || NEUTRAL_US + 498 >= PERIOD_US ||
        CYCLES_PER_US < 1 || SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_param_check
        $error("pwm_pulse_gen: invalid parameter set");
    end

    logic [PRE_W-1:0] us_pre;
    logic [CNT_W-1:0] us_cnt;
    logic             enable_q;

    logic [7:0]       active_ratio;
    logic             active_dir;
    logic [7:0]       pending_ratio;
    logic             pending_dir;
    logic             pending_valid;

    logic [7:0]       next_ratio;
    logic             next_dir;
    logic             next_matches;

    logic [16:0]      offset_full;
    logic [8:0]       offset_us;
    logic [CNT_W-1:0] pulse_us;

    logic             running;
    logic             starting;
    logic             pre_wrap;
    logic             boundary;

    // First enabled cycle is spent with counters at zero so the frame that
    // follows starts cleanly with period_start.
    assign running  = pwm_enable & enable_q;
    assign starting = pwm_enable & ~enable_q;
    assign pre_wrap = (us_pre == PRE_LAST);
    assign boundary = running & pre_wrap & (us_cnt == CNT_LAST);

    // 255 * 500 / 256 = 498, so the offset always fits in 9 bits.
    assign offset_full = 17'(active_ratio) * 17'd500;
    assign offset_us   = 9'(offset_full >> 8);
    assign pulse_us    = active_dir ? (NEUTRAL - CNT_W'(offset_us))
                                    : (NEUTRAL + CNT_W'(offset_us));

    // Value the active register takes at the next boundary while a request
    // is pending.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        next_ratio = active_ratio;
        next_dir   = active_dir;
`ifdef PWM_SLEW_LIMIT_EN
        if (active_dir != pending_dir) begin
            if (active_ratio == 8'd0) begin
                // Flip at zero and start climbing in the new direction.
                next_dir   = pending_dir;
                next_ratio = (pending_ratio > 8'(SLEW_STEP)) ? 8'(SLEW_STEP) : pending_ratio;
            end else begin
                next_ratio = (active_ratio > 8'(SLEW_STEP)) ? active_ratio - 8'(SLEW_STEP) : 8'd0;
            end
        end else if (pending_ratio > active_ratio) begin
            next_ratio = (pending_ratio - active_ratio > 8'(SLEW_STEP))
                       ? active_ratio + 8'(SLEW_STEP) : pending_ratio;
        end else begin
            next_ratio = (active_ratio - pending_ratio > 8'(SLEW_STEP))
                       ? active_ratio - 8'(SLEW_STEP) : pending_ratio;
        end
`else
        next_ratio = pending_ratio;
        next_dir   = pending_dir;
`endif
        next_matches = (next_ratio == pending_ratio) && (next_dir == pending_dir);
    end

    // Frame timing and the registered output.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of the others.
        if (!reset_n) begin
            us_pre       <= '0;
            us_cnt       <= '0;
            enable_q     <= 1'b0;
            period_start <= 1'b0;
            pwm_signal   <= 1'b0;
        end else begin
            enable_q     <= pwm_enable;
            period_start <= starting | boundary;
            pwm_signal   <= running & (us_cnt < pulse_us);
            if (!running) begin
                us_pre <= '0;
                us_cnt <= '0;
            end else if (pre_wrap) begin
                us_pre <= '0;
                us_cnt <= (us_cnt == CNT_LAST) ? '0 : us_cnt + CNT_ONE;
            end else begin
                us_pre <= us_pre + PRE_ONE;
            end
        end
    end

    // Request capture and application.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active_ratio  <= '0;
            active_dir    <= 1'b0;
            pending_ratio <= '0;
            pending_dir   <= 1'b0;
            pending_valid <= 1'b0;
            pwm_done      <= 1'b0;
        end else begin
            pwm_done <= 1'b0;
            if (!pwm_enable) begin
                // No frame to align to: requests take effect at once.
                if (pwm_update) begin
                    active_ratio  <= pwm_ratio;
                    active_dir    <= pwm_direction;
                    pending_ratio <= pwm_ratio;
                    pending_dir   <= pwm_direction;
                    pending_valid <= 1'b0;
                    pwm_done      <= 1'b1;
                end else if (pending_valid) begin
                    active_ratio  <= pending_ratio;
                    active_dir    <= pending_dir;
                    pending_valid <= 1'b0;
                    pwm_done      <= 1'b1;
                end
            end else begin
                if (boundary && pending_valid) begin
                    active_ratio <= next_ratio;
                    active_dir   <= next_dir;
                    if (next_matches) begin
                        pending_valid <= 1'b0;
                        pwm_done      <= 1'b1;
                    end
                end
                // Placed last so a strobe on the boundary cycle keeps
                // pending_valid set and waits for the following boundary.
                if (pwm_update) begin
                    pending_ratio <= pwm_ratio;
                    pending_dir   <= pwm_direction;
                    pending_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_pulse_gen.sv
// tb_pwm_pulse_gen
//   Self-checking bench for pwm_pulse_gen at CYCLES_PER_US=2, PERIOD_US=2500
//   (5000-clock frames). Expected pulse widths come from the microsecond
//   formula; request timing is tracked as "next frame" / "frame after next".
module tb_pwm_pulse_gen;

    localparam int C     = 2;
    localparam int P     = 2500;
    localparam int N     = 1500;
    localparam int FRAME = C * P;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       pwm_enable;
    logic [7:0] pwm_ratio;
    logic       pwm_direction;
    logic       pwm_update;
    logic       pwm_done;
    logic       pwm_signal;
    logic       period_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] ratio;
        logic       dir;
        int         exp_us;
    } vec_t;

    vec_t vecs[5];
    int   slew_us[5];
    int   slew_done[5];

    // Reference model: active value, request due at the next boundary, and
    // request held for the boundary after that.
    int m_r, m_d, m_applied;
    int m_next_valid, m_next_r, m_next_d;
    int m_late_valid, m_late_r, m_late_d;

    int         f_high, f_len, f_done0, f_dones;
    int         s1_at, s2_at;
    logic [7:0] s1_r, s2_r;
    logic       s1_d, s2_d;
    int         high;

    always #5 clock = ~clock;

    pwm_pulse_gen #(
        .CYCLES_PER_US(C),
        .PERIOD_US    (P),
        .NEUTRAL_US   (N),
        .SLEW_STEP    (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pwm_enable   (pwm_enable),
        .pwm_ratio    (pwm_ratio),
        .pwm_direction(pwm_direction),
        .pwm_update   (pwm_update),
        .pwm_done     (pwm_done),
        .pwm_signal   (pwm_signal),
        .period_start (period_start)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic int pulse_clocks(input int r, input int d);
        int off;
        off = (r * 500) / 256;
        return C * ((d != 0) ? N - off : N + off);
    endfunction

    task automatic model_strobe(input int at, input logic [7:0] r, input logic d);
        if (at == FRAME - 1) begin
            m_late_valid = 1; m_late_r = r; m_late_d = d;
        end else begin
            m_next_valid = 1; m_next_r = r; m_next_d = d;
        end
    endtask

    task automatic model_clear(input int r, input int d);
        m_r = r; m_d = d; m_applied = 0;
        m_next_valid = 0; m_late_valid = 0;
    endtask

    // Starts at the negedge where period_start is high (frame offset 0) and
    // returns at the negedge of the next period_start. Up to two strobes.
    task automatic measure_frame(input int a1, input logic [7:0] r1, input logic d1,
                                 input int a2, input logic [7:0] r2, input logic d2,
                                 output int hi, output int len, output int d0, output int dn);
        hi = 0; len = -1; dn = 0;
        d0 = int'(pwm_done);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i > 0 && period_start) begin
                len = i;
                break;
            end
            hi += int'(pwm_signal);
            dn += int'(pwm_done);
            pwm_update = 1'b0;
            if (i == a1) begin
                pwm_update = 1'b1; pwm_ratio = r1; pwm_direction = d1;
                model_strobe(i, r1, d1);
            end
            if (i == a2) begin
                pwm_update = 1'b1; pwm_ratio = r2; pwm_direction = d2;
                model_strobe(i, r2, d2);
            end
            tick();
        end
        pwm_update = 1'b0;
    endtask

    task automatic run_frame(input string name, input int a1, input logic [7:0] r1, input logic d1,
                             input int a2, input logic [7:0] r2, input logic d2);
        int exp_high;
        exp_high = pulse_clocks(m_r, m_d);
        measure_frame(a1, r1, d1, a2, r2, d2, f_high, f_len, f_done0, f_dones);
        check({name, " high"},  f_high,  exp_high);
        check({name, " len"},   f_len,   FRAME);
        check({name, " done0"}, f_done0, m_applied);
        check({name, " dones"}, f_dones, m_applied);
        m_applied = m_next_valid;
        if (m_next_valid != 0) begin
            m_r = m_next_r; m_d = m_next_d;
        end
        m_next_valid = m_late_valid; m_next_r = m_late_r; m_next_d = m_late_d;
        m_late_valid = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd0,   1'b1, 1500};
        vecs[1] = '{8'd255, 1'b1, 1002};
        vecs[2] = '{8'd1,   1'b0, 1501};
        vecs[3] = '{8'd200, 1'b0, 1890};
        vecs[4] = '{8'd100, 1'b1, 1305};
        slew_us   = '{1562, 1531, 1500, 1469, 1438};
        slew_done = '{0, 0, 0, 0, 1};

        reset_n = 1'b0; pwm_enable = 1'b1; pwm_update = 1'b0;
        pwm_ratio = 8'd0; pwm_direction = 1'b0;
        repeat (3) tick();
        check("reset pwm_done", pwm_done, 0);
        check("reset pwm_signal", pwm_signal, 0);
        check("reset period_start", period_start, 0);

        reset_n = 1'b1;
        tick();
        check("first period_start", period_start, 1);
        model_clear(0, 0);

`ifdef PWM_SLEW_LIMIT_EN
        pwm_enable = 1'b0;
        tick();
        pwm_update = 1'b1; pwm_ratio = 8'd32; pwm_direction = 1'b0;
        tick();
        pwm_update = 1'b0;
        check("slew preset done", pwm_done, 1);
        pwm_enable = 1'b1;
        tick();
        check("slew start", period_start, 1);
        measure_frame(100, 8'd32, 1'b1, -1, 8'd0, 1'b0, f_high, f_len, f_done0, f_dones);
        check("slew f0 high", f_high, C * 1562);
        check("slew f0 dones", f_dones, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                measure_frame(-1, 8'd0, 1'b0, -1, 8'd0, 1'b0, f_high, f_len, f_done0, f_dones);
                check($sformatf("slew f%0d high", k), f_high, C * slew_us[k]);
                check($sformatf("slew f%0d done0", k), f_done0, slew_done[k]);
                check($sformatf("slew f%0d dones", k), f_dones, slew_done[k]);
                check($sformatf("slew f%0d len", k), f_len, FRAME);
            end
        end
`else
        // Idle frames, then a mid-frame request, last-wins, boundary strobe.
        run_frame("idle0",      -1,        8'd0,   1'b0, -1,   8'd0, 1'b0);
        run_frame("idle1",      -1,        8'd0,   1'b0, -1,   8'd0, 1'b0);
        run_frame("upd128",     1234,      8'd128, 1'b0, -1,   8'd0, 1'b0);
        run_frame("apply128",   700,       8'd255, 1'b1, 2100, 8'd0, 1'b0);
        run_frame("lastwins",   FRAME - 1, 8'd255, 1'b0, -1,   8'd0, 1'b0);
        run_frame("edge_hold",  -1,        8'd0,   1'b0, -1,   8'd0, 1'b0);
        run_frame("edge_apply", -1,        8'd0,   1'b0, -1,   8'd0, 1'b0);

        // Disable in the middle of a pulse.
        repeat (100) tick();
        check("mid pulse high", pwm_signal, 1);
        pwm_enable = 1'b0;
        tick();
        check("disable signal low", pwm_signal, 0);
        high = 0;
        for (int i = 0; i < 10; i++) begin
            high += int'(period_start);
            tick();
        end
        check("disabled no period_start", high, 0);
        pwm_update = 1'b1; pwm_ratio = 8'd64; pwm_direction = 1'b0;
        tick();
        pwm_update = 1'b0;
        check("disabled done", pwm_done, 1);
        tick();
        check("disabled done single", pwm_done, 0);
        pwm_enable = 1'b1;
        tick();
        check("reenable period_start", period_start, 1);
        model_clear(64, 0);
        run_frame("reenable64", -1, 8'd0, 1'b0, -1, 8'd0, 1'b0);

        // Randomized requests against the model.
        for (int k = 0; k < 2; k++) begin
            s1_at = int'($urandom_range(FRAME - 2, 0));
            s1_r  = 8'($urandom_range(255, 0));
            s1_d  = 1'($urandom_range(1, 0));
            s2_at = ($urandom_range(1, 0) != 0) ? int'($urandom_range(FRAME - 1, s1_at + 1)) : -1;
            s2_r  = 8'($urandom_range(255, 0));
            s2_d  = 1'($urandom_range(1, 0));
            run_frame($sformatf("rand%0d", k), s1_at, s1_r, s1_d, s2_at, s2_r, s2_d);
        end
        run_frame("rand_drain", -1, 8'd0, 1'b0, -1, 8'd0, 1'b0);

        // Table of pulse widths, each loaded while disabled.
        pwm_enable = 1'b0;
        tick();
        foreach (vecs[v]) begin
            pwm_update = 1'b1; pwm_ratio = vecs[v].ratio; pwm_direction = vecs[v].dir;
            tick();
            pwm_update = 1'b0;
            check($sformatf("vec%0d done", v), pwm_done, 1);
            pwm_enable = 1'b1;
            tick();
            check($sformatf("vec%0d start", v), period_start, 1);
            high = 0;
            for (int i = 0; i < 4100; i++) begin
                high += int'(pwm_signal);
                tick();
            end
            check($sformatf("vec%0d high", v), high, C * vecs[v].exp_us);
            pwm_enable = 1'b0;
            tick();
        end

        // Reset with a request pending discards it.
        pwm_enable = 1'b1;
        repeat (20) tick();
        pwm_update = 1'b1; pwm_ratio = 8'd50; pwm_direction = 1'b0;
        tick();
        pwm_update = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        #1;
        check("async reset signal", pwm_signal, 0);
        check("async reset done", pwm_done, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post reset start", period_start, 1);
        model_clear(0, 0);
        run_frame("post_reset", -1, 8'd0, 1'b0, -1, 8'd0, 1'b0);
        check("pending discarded", pwm_done, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
